// File: rtl/apb_slave_mem.sv
// APB completer fronting a word-addressed 32-bit register memory.
// Inserts WAIT_CYCLES wait states per access and flags indices >= DEPTH with PSLVERR.
module apb_slave_mem #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic        PREADY,
    output logic [31:0] PRDATA,
    output logic        PSLVERR
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  addr_reg, addr_next;
    logic        wr_reg, wr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        err_reg, err_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        pready_reg, pready_next;
    logic        pslverr_reg, pslverr_next;
    logic [31:0] prdata_reg, prdata_next;

    logic [31:0] mem_reg [DEPTH];
    logic [DEPTH-1:0] word_we;
    logic        mem_we;

    logic        setup;
    logic        setup_err;
    logic [31:0] rd_word_latched;
    logic [31:0] rd_word_setup;

    logic        do_cpl;
    logic        cpl_wr;
    logic        cpl_err;
    logic [31:0] cpl_word;

    // Upper address bits select between instances upstream and are not decoded here.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^PADDR[31:8];

    assign setup           = PSEL && !PENABLE;
    assign setup_err       = ({1'b0, PADDR[7:0]} >= DEPTH_LIM);
    assign rd_word_latched = mem_reg[addr_reg[AW-1:0]];
    assign rd_word_setup   = mem_reg[PADDR[AW-1:0]];

    // The commit needs the master to still be in the access phase at the closing edge.
    assign mem_we = (state_reg == READY) && PSEL && PENABLE && wr_reg && !err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word_we
            assign word_we[gi] = mem_we && (addr_reg == 8'(gi));
        end
    endgenerate

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (word_we[i]) begin
                    mem_reg[i] <= wdata_reg;
                end
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            wr_reg      <= 1'b0;
            wdata_reg   <= '0;
            err_reg     <= 1'b0;
            cnt_reg     <= '0;
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
            prdata_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            wr_reg      <= wr_next;
            wdata_reg   <= wdata_next;
            err_reg     <= err_next;
            cnt_reg     <= cnt_next;
            pready_reg  <= pready_next;
            pslverr_reg <= pslverr_next;
            prdata_reg  <= prdata_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        wr_next      = wr_reg;
        wdata_next   = wdata_reg;
        err_next     = err_reg;
        cnt_next     = cnt_reg;
        pready_next  = pready_reg;
        pslverr_next = pslverr_reg;
        prdata_next  = prdata_reg;
        do_cpl       = 1'b0;
        cpl_wr       = wr_reg;
        cpl_err      = err_reg;
        cpl_word     = rd_word_latched;

        case (state_reg)
            IDLE: begin
                pready_next  = 1'b0;
                pslverr_next = 1'b0;
                if (setup) begin
                    addr_next  = PADDR[7:0];
                    wr_next    = PWRITE;
                    wdata_next = PWDATA;
                    err_next   = setup_err;
                    // Zero-wait builds complete straight from setup, so use the live bus values.
                    if (WAIT_CYCLES == 0) begin
                        do_cpl   = 1'b1;
                        cpl_wr   = PWRITE;
                        cpl_err  = setup_err;
                        cpl_word = rd_word_setup;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_next = IDLE;
                end else if (cnt_reg == 4'd0) begin
                    do_cpl = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            READY: begin
                state_next   = IDLE;
                pready_next  = 1'b0;
                pslverr_next = 1'b0;
            end
            default: begin
                state_next   = IDLE;
                pready_next  = 1'b0;
                pslverr_next = 1'b0;
            end
        endcase

        if (do_cpl) begin
            state_next   = READY;
            pready_next  = 1'b1;
            pslverr_next = cpl_err;
            if (!cpl_wr) begin
                prdata_next = cpl_err ? 32'h0 : cpl_word;
            end
        end
    end

    assign PREADY  = pready_reg;
    assign PSLVERR = pslverr_reg;
    assign PRDATA  = prdata_reg;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench: two completers on one APB bus (64 words / 2 waits and 256 words / zero wait),
// driven by a master task with a queue-based scoreboard checked by an independent monitor.
module tb_apb_slave_mem;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [1:0]  psel;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        pready0, pready1;
    logic        pslverr0, pslverr1;
    logic [31:0] prdata0, prdata1;

    always #5 PCLK = ~PCLK;

    apb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(2)) u_mem0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0)
    );

    apb_slave_mem #(.DEPTH(256), .WAIT_CYCLES(0)) u_mem1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(pready1), .PRDATA(prdata1), .PSLVERR(pslverr1)
    );

    typedef struct {
        int          slave;
        int          cyc;
        bit          wr;
        bit          err;
        logic [7:0]  addr;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [2][256];
    logic [31:0] last_rd [2];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          txn   = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic int depth_of(int s);
        return (s == 1) ? 256 : 64;
    endfunction

    function automatic int waits_of(int s);
        return (s == 1) ? 0 : 2;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) model_mem[s][i] = 32'h0;
            last_rd[s] = 32'h0;
        end
    endtask

    // Monitor: every PREADY pulse must match the oldest outstanding expectation.
    exp_t        mon_e;
    int          mon_s;
    logic        mon_err;
    logic [31:0] mon_rd;
    always @(negedge PCLK) begin
        if (pready0 || pready1) begin
            tests++;
            mon_s   = pready1 ? 1 : 0;
            mon_err = pready1 ? pslverr1 : pslverr0;
            mon_rd  = pready1 ? prdata1 : prdata0;
            if (pready0 && pready1) begin
                fails++;
                $display("[TB] FAIL both_pready cyc=%0d: got both slaves ready, required one", cyc);
            end else if (sb_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_pready cyc=%0d slave=%0d: got PREADY=1, required 0", cyc, mon_s);
            end else begin
                mon_e = sb_q.pop_front();
                txn++;
                if (mon_e.slave != mon_s || mon_e.cyc != cyc || mon_e.err !== mon_err
                    || mon_e.rdata !== mon_rd) begin
                    fails++;
                    $display("[TB] FAIL txn%0d %s slave=%0d addr=%02h: got slave=%0d cyc=%0d err=%0b rdata=%08h, required slave=%0d cyc=%0d err=%0b rdata=%08h",
                             txn, mon_e.wr ? "wr" : "rd", mon_e.slave, mon_e.addr, mon_s, cyc,
                             mon_err, mon_rd, mon_e.slave, mon_e.cyc, mon_e.err, mon_e.rdata);
                end else begin
                    $display("[TB] txn%0d %s slave=%0d addr=%02h err=%0b rdata=%08h cyc=%0d ok",
                             txn, mon_e.wr ? "wr" : "rd", mon_s, mon_e.addr, mon_err, mon_rd, cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic bus_idle(int n);
        repeat (n) begin
            tick();
            psel    = 2'b00;
            PENABLE = 1'b0;
            PWRITE  = 1'($urandom);
            PADDR   = $urandom;
            PWDATA  = $urandom;
        end
    endtask

    task automatic check_reset_outputs();
        @(negedge PCLK);
        tests++;
        if (pready0 !== 1'b0 || pslverr0 !== 1'b0 || prdata0 !== 32'h0
            || pready1 !== 1'b0 || pslverr1 !== 1'b0 || prdata1 !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got rdy=%0b/%0b err=%0b/%0b rd=%08h/%08h, required all 0",
                     pready0, pready1, pslverr0, pslverr1, prdata0, prdata1);
        end else begin
            $display("[TB] reset outputs all zero ok");
        end
    endtask

    // mode: 0 normal, 1 drop PSEL during WAIT, 2 drop PSEL during READY, 3 reset during WAIT
    task automatic xfer(int s, bit wr, logic [7:0] a, logic [31:0] d, int mode);
        bit   err;
        bit   done;
        exp_t e;
        err = (int'(a) >= depth_of(s));
        tick();
        psel    = (s == 1) ? 2'b10 : 2'b01;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = {23'($urandom), 1'(s), a};
        PWDATA  = d;
        if (mode == 0 || mode == 2) begin
            e.slave = s;
            e.cyc   = cyc + 1 + waits_of(s);
            e.wr    = wr;
            e.err   = err;
            e.addr  = a;
            e.rdata = wr ? last_rd[s] : (err ? 32'h0 : model_mem[s][a]);
            if (!wr) last_rd[s] = e.rdata;
            sb_q.push_back(e);
        end
        tick();
        PENABLE = 1'b1;
        PADDR   = $urandom;
        PWDATA  = $urandom;
        if (mode == 1) begin
            tick();
            psel    = 2'b00;
            PENABLE = 1'b0;
            return;
        end
        if (mode == 3) begin
            tick();
            PRESETn = 1'b0;
            psel    = 2'b00;
            PENABLE = 1'b0;
            tick();
            PRESETn = 1'b1;
            model_reset();
            return;
        end
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge PCLK);
            if ((s == 1) ? pready1 : pready0) done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("[TB] FAIL timeout slave=%0d addr=%02h: got no PREADY in 20 cycles, required PREADY", s, a);
        end else if (mode == 2) begin
            psel    = 2'b00;
            PENABLE = 1'b0;
        end else if (wr && !err) begin
            model_mem[s][a] = d;
        end
    endtask

    task automatic stray(int s, logic [7:0] a, logic [31:0] d);
        tick();
        psel    = (s == 1) ? 2'b10 : 2'b01;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = {24'h0, a};
        PWDATA  = d;
        repeat (4) tick();
        tick();
        psel    = 2'b00;
        PENABLE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by 200000, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s;
        bit          wr;
        logic [7:0]  a;
        PRESETn = 1'b0;
        psel    = 2'b00;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 32'h0;
        PWDATA  = 32'h0;
        model_reset();
        tick();
        tick();
        PRESETn = 1'b1;
        check_reset_outputs();

        xfer(0, 0, 8'h05, 32'h0, 0);
        xfer(0, 1, 8'h10, 32'hDEADBEEF, 0);
        xfer(0, 0, 8'h10, 32'h0, 0);

        xfer(0, 1, 8'h3F, 32'h13579BDF, 0);
        xfer(0, 1, 8'h40, 32'h12345678, 0);
        xfer(0, 0, 8'h40, 32'h0, 0);
        xfer(0, 0, 8'h3F, 32'h0, 0);
        xfer(0, 0, 8'h00, 32'h0, 0);

        xfer(1, 1, 8'h3F, 32'hA5A5A5A5, 0);
        xfer(1, 0, 8'h3F, 32'h0, 0);
        xfer(1, 1, 8'hFF, 32'h0F0F1234, 0);
        xfer(1, 0, 8'hFF, 32'h0, 0);
        xfer(0, 0, 8'h3F, 32'h0, 0);

        xfer(0, 1, 8'h20, 32'hCAFEF00D, 1);
        bus_idle(3);
        xfer(0, 0, 8'h20, 32'h0, 0);
        xfer(1, 1, 8'h21, 32'h87654321, 2);
        bus_idle(1);
        xfer(1, 0, 8'h21, 32'h0, 0);
        xfer(0, 1, 8'h22, 32'h55AA55AA, 2);
        xfer(0, 0, 8'h22, 32'h0, 0);

        xfer(0, 1, 8'h05, 32'h0BADF00D, 0);
        stray(0, 8'h05, 32'hFFFF0000);
        stray(1, 8'h06, 32'hFFFF0001);
        xfer(0, 0, 8'h05, 32'h0, 0);
        xfer(1, 0, 8'h06, 32'h0, 0);

        xfer(0, 1, 8'h01, 32'h11111111, 0);
        xfer(0, 1, 8'h01, 32'h22222222, 3);
        check_reset_outputs();
        xfer(0, 0, 8'h01, 32'h0, 0);
        xfer(0, 0, 8'h10, 32'h0, 0);
        xfer(1, 0, 8'h3F, 32'h0, 0);

        for (int n = 0; n < 200; n++) begin
            s  = int'($urandom_range(0, 1));
            wr = 1'($urandom);
            if (s == 0)
                a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(56, 71)) : 8'($urandom_range(0, 127));
            else
                a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(240, 255));
            if ($urandom_range(0, 15) == 0 && s == 0)
                xfer(s, wr, a, $urandom, 1);
            else if ($urandom_range(0, 15) == 0)
                xfer(s, wr, a, $urandom, 2);
            else
                xfer(s, wr, a, $urandom, 0);
            if ($urandom_range(0, 3) == 0) bus_idle(int'($urandom_range(1, 2)));
        end

        bus_idle(4);
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d outstanding, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer that terminates one PSEL line from the system's APB master and fronts a word-addressed 32-bit register memory. It decodes setup/access phases, inserts a programmable number of wait states via PREADY, performs reads and writes, and flags out-of-range accesses with PSLVERR. Two instances sit behind the master's two select lines, one per PSEL, with PADDR[8] choosing between them upstream.

## Interface
- DEPTH, 64: number of 32-bit words. Range 1..256. Index is PADDR[7:0].
- WAIT_CYCLES, 2: wait states inserted per access. Range 0..15.
- PCLK, input, 1: clock. All logic on the rising edge.
- PRESETn, input, 1: synchronous, active-low reset, sampled on the PCLK rising edge.
- PSEL, input, 1: slave select from the master.
- PENABLE, input, 1: access-phase indicator.
- PWRITE, input, 1: 1 = write, 0 = read.
- PADDR, input, 32: address. Only PADDR[7:0] is used; PADDR[31:8] is ignored.
- PWDATA, input, 32: write data.
- PREADY, output, 1: transfer-complete strobe. Registered.
- PRDATA, output, 32: read data. Registered.
- PSLVERR, output, 1: error response. Registered. Meaningful only while PREADY=1.

## Operation
- State machine has three states: IDLE, WAIT and READY.
- **IDLE** (PREADY=0, PSLVERR=0):
  - Setup is detected as PSEL=1 with PENABLE=0.
  - On setup, latch addr_q=PADDR[7:0], wr_q=PWRITE, wdata_q=PWDATA, err_q=(PADDR[7:0] >= DEPTH).
  - If WAIT_CYCLES==0, go to READY (see completion load below).
  - Otherwise go to WAIT with cnt=WAIT_CYCLES-1.
  - PENABLE=1 without a preceding setup is ignored; the block stays in IDLE.
- **WAIT** (PREADY=0):
  - If PSEL=0 (master abort), go to IDLE. No memory change; PRDATA unchanged.
  - Else if cnt==0, go to READY with the completion load.
  - Else decrement cnt.
- **Completion load** (on the edge entering READY):
  - PREADY<=1 and PSLVERR<=err_q.
  - For a read with no error: PRDATA<=mem[addr_q].
  - For a read with error: PRDATA<=0.
  - For a write: PRDATA holds its value.
- **READY** (PREADY=1 for exactly one cycle):
  - At the end of this cycle, if PSEL&PENABLE&wr_q&!err_q, write mem[addr_q]<=wdata_q.
  - Always go to IDLE with PREADY<=0 and PSLVERR<=0.
- Memory is cleared to 0 on reset.
- Out-of-range writes are dropped. PSLVERR=1 with PREADY=1 is the only effect.
- PWDATA and PADDR changes after the setup cycle are ignored; the latched values are used.

## Timing
- Reset (PRESETn=0 at an edge):
  - state=IDLE, PREADY=0, PRDATA=0, PSLVERR=0, cnt=0, all memory words 0.
  - Any in-flight transfer is dropped with no write committed.
  - Reset has priority over every other event.
- Setup at cycle T. PREADY is high during cycle T+1+WAIT_CYCLES.
  - The access phase lasts WAIT_CYCLES+1 cycles.
  - Total transfer time is WAIT_CYCLES+2 cycles including setup.
  - With WAIT_CYCLES=0, PREADY is high in the first access cycle (zero-wait).
- PRDATA is valid in the same cycle as PREADY and holds until the next read completion or reset.
- Write commits at the edge that ends the PREADY cycle. A read issued in the next setup sees the new data.
- Back-to-back transfers: the cycle after READY is a setup cycle, detected from IDLE. No dead cycle is required.
- Minimum transfer period is WAIT_CYCLES+2 cycles.
- Abort: PSEL deasserted during WAIT returns to IDLE at the next edge. If PSEL deasserts during READY, the write is not committed.
- Boundaries:
  - addr = DEPTH-1 is valid; addr = DEPTH is an error.
  - With DEPTH=256, no index is an error.

## Test plan
- Reset then read: apply PRESETn=0 for 2 cycles, then read addr 0x05 with WAIT_CYCLES=2 -> PREADY high exactly 3 cycles after setup, PRDATA=0x00000000, PSLVERR=0.
- Write then read: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> PRDATA=0xDEADBEEF. Each transfer takes 4 cycles, PSLVERR=0.
- Out of range: with DEPTH=64, write 0x12345678 to 0x40, then read 0x40 -> both give PSLVERR=1 with PREADY=1. The read returns PRDATA=0. A read of 0x3F still returns its prior value.
- Zero wait: build with WAIT_CYCLES=0 and run a write/read of 0xA5A5A5A5 at 0x3F -> PREADY in the first access cycle, data returned correctly, 2-cycle transfers.
- Abort and reset mid-operation:
  - Drop PSEL during WAIT -> returns to IDLE, no write, PREADY never asserted.
  - Assert PRESETn=0 during WAIT of a write to 0x01 -> outputs 0, and a subsequent read of 0x01 returns 0.
- Stray PENABLE: hold PENABLE=1, PSEL=1 without a setup cycle from IDLE -> PREADY stays 0 and memory is unchanged.
